// File: rtl/x2821_pkg.sv
// Shared types and helpers for the 2821 carriage control slice.
package x2821_pkg;

  localparam int unsigned CHAN_W = 4;
  localparam int unsigned NCHAN  = 12;

  typedef enum logic [2:0] {
    IDLE,
    SPACE,
    SKIP_HI,
    SKIP_LO,
    SETTLE
  } state_t;

  typedef struct packed {
    logic              skip;
    logic [1:0]        count;
    logic [CHAN_W-1:0] channel;
  } cmd_t;

  // One-hot brush mask for a carriage channel; out-of-range channels give no bits.
  function automatic logic [NCHAN-1:0] chan_mask(input logic [CHAN_W-1:0] ch);
    logic [NCHAN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (ch == CHAN_W'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic cmd_ok(input cmd_t c);
    if (c.skip) return (c.channel >= CHAN_W'(1)) && (c.channel <= CHAN_W'(NCHAN));
    else        return c.count != 2'd0;
  endfunction

endpackage

// File: rtl/x2821_rise_det.sv
// Rising-edge detector against a registered one-cycle history of the input bus.
module x2821_rise_det #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= '0;
    else         r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/x2821_carriage_ctl.sv
// 2821 carriage control: runs space / skip-to-channel commands on a 1403 carriage,
// driving the clutches from mag-emitter line counts and slow/stop brush edges.
module x2821_carriage_ctl
  import x2821_pkg::*;
#(
  parameter int unsigned LINE_TIMEOUT   = 4096,
  parameter int unsigned SETTLE_CYCLES  = 750,
  parameter int unsigned MAX_SKIP_LINES = 132
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_skip,
  input  logic [1:0]        i_cmd_count,
  input  logic [CHAN_W-1:0] i_cmd_channel,
  output logic              o_low_speed_start,
  output logic              o_low_speed_stop,
  output logic              o_high_speed_start,
  output logic              o_high_speed_stop,
  input  logic              i_mag_emitter,
  input  logic [NCHAN-1:0]  i_slow_brushes,
  input  logic [NCHAN-1:0]  i_stop_brushes,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [7:0]        o_lines
);

  localparam int unsigned      TMO_W     = $clog2(LINE_TIMEOUT);
  localparam int unsigned      SET_W     = $clog2(SETTLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LINE_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_DONE  = SET_W'(SETTLE_CYCLES - 2);
  localparam logic [7:0]       SKIP_LAST = 8'(MAX_SKIP_LINES - 1);

  state_t           r_state;
  logic             r_lo;
  logic             r_hi;
  logic             r_done;
  logic             r_error;
  logic             r_err_flag;
  logic [7:0]       r_lines;
  logic [1:0]       r_count;
  logic [NCHAN-1:0] r_mask;
  logic [TMO_W-1:0] r_tmo;
  logic [SET_W-1:0] r_settle;

  cmd_t             w_cmd;
  logic             w_mag_rise;
  logic [NCHAN-1:0] w_slow_rise;
  logic [NCHAN-1:0] w_stop_rise;
  logic             w_slow_hit;
  logic             w_stop_hit;

  assign w_cmd = '{skip: i_cmd_skip, count: i_cmd_count, channel: i_cmd_channel};

  x2821_rise_det #(.W(1)) u_mag_det (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_mag_emitter),
    .o_rise (w_mag_rise)
  );

  x2821_rise_det #(.W(NCHAN)) u_slow_det (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_slow_brushes),
    .o_rise (w_slow_rise)
  );

  x2821_rise_det #(.W(NCHAN)) u_stop_det (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_stop_brushes),
    .o_rise (w_stop_rise)
  );

  assign w_slow_hit = |(w_slow_rise & r_mask);
  assign w_stop_hit = |(w_stop_rise & r_mask);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_lo       <= 1'b0;
      r_hi       <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_flag <= 1'b0;
      r_lines    <= '0;
      r_count    <= '0;
      r_mask     <= '0;
      r_tmo      <= '0;
      r_settle   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      // Lines keep counting through settle so carriage coast shows up in o_lines.
      if (r_state != IDLE && w_mag_rise && r_lines != 8'hFF) r_lines <= r_lines + 8'd1;

      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_count    <= i_cmd_count;
            r_mask     <= chan_mask(i_cmd_channel);
            r_lines    <= '0;
            r_tmo      <= '0;
            r_settle   <= '0;
            r_err_flag <= ~cmd_ok(w_cmd);
            if (!cmd_ok(w_cmd)) begin
              r_state <= SETTLE;
            end else if (i_cmd_skip) begin
              r_lo    <= 1'b1;
              r_hi    <= 1'b1;
              r_state <= SKIP_HI;
            end else begin
              r_lo    <= 1'b1;
              r_state <= SPACE;
            end
          end
        end

        SPACE: begin
          if (w_mag_rise) begin
            r_tmo <= '0;
            if ((r_lines + 8'd1) == {6'd0, r_count}) begin
              r_lo    <= 1'b0;
              r_state <= SETTLE;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_lo       <= 1'b0;
            r_err_flag <= 1'b1;
            r_state    <= SETTLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        SKIP_HI, SKIP_LO: begin
          // Stop brush outranks the line limit, timeout and a coincident slow brush.
          if (w_stop_hit) begin
            r_lo    <= 1'b0;
            r_hi    <= 1'b0;
            r_state <= SETTLE;
          end else if ((w_mag_rise && r_lines == SKIP_LAST) ||
                       (!w_mag_rise && r_tmo == TMO_LAST)) begin
            r_lo       <= 1'b0;
            r_hi       <= 1'b0;
            r_err_flag <= 1'b1;
            r_state    <= SETTLE;
          end else begin
            r_tmo <= w_mag_rise ? '0 : r_tmo + 1'b1;
            if (r_state == SKIP_HI && w_slow_hit) begin
              r_hi    <= 1'b0;
              r_state <= SKIP_LO;
            end
          end
        end

        SETTLE: begin
          if (r_settle == SET_LAST) begin
            r_state <= IDLE;
          end else begin
            r_settle <= r_settle + 1'b1;
            if (r_settle == SET_DONE) begin
              r_done  <= 1'b1;
              r_error <= r_err_flag;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready        = (r_state == IDLE);
  assign o_busy             = (r_state != IDLE);
  assign o_low_speed_start  = r_lo;
  assign o_low_speed_stop   = ~r_lo;
  assign o_high_speed_start = r_hi;
  assign o_high_speed_stop  = ~r_hi;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_lines            = r_lines;

endmodule

// File: tb/tb_x2821_carriage_ctl.sv
// Bench for x2821_carriage_ctl: directed and random commands against an event-level model
// that predicts drop edges, done timing, error and line count from the stimulus schedule.
module tb_x2821_carriage_ctl;

  localparam int LT   = 4096;
  localparam int SC   = 750;
  localparam int MAXL = 132;
  localparam int INF  = 32'h3fffffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_skip;
  logic [1:0]  i_cmd_count;
  logic [3:0]  i_cmd_channel;
  logic        o_lo_start, o_lo_stop, o_hi_start, o_hi_stop;
  logic        i_mag;
  logic [11:0] i_slow, i_stop;
  logic        o_busy, o_done, o_error;
  logic [7:0]  o_lines;

  always #5 clk = ~clk;

  x2821_carriage_ctl #(
    .LINE_TIMEOUT  (LT),
    .SETTLE_CYCLES (SC),
    .MAX_SKIP_LINES(MAXL)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_skip        (i_cmd_skip),
    .i_cmd_count       (i_cmd_count),
    .i_cmd_channel     (i_cmd_channel),
    .o_low_speed_start (o_lo_start),
    .o_low_speed_stop  (o_lo_stop),
    .o_high_speed_start(o_hi_start),
    .o_high_speed_stop (o_hi_stop),
    .i_mag_emitter     (i_mag),
    .i_slow_brushes    (i_slow),
    .i_stop_brushes    (i_stop),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_lines           (o_lines)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus schedule for the next command, in edges after the accepting edge.
  int q_rise[$];
  int slow_e;
  int stop_e;
  bit noise;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, o_cmd_ready, 1);
  endtask

  task automatic run(input string tag, input bit skip, input int cnt, input int ch);
    int d, t_tmo, t_line, t_stop, prev, hi_exp, done_exp, lines_exp, limit, ri;
    int lo_fall, hi_fall, done_k, lines_seen;
    bit valid, err_exp, err_seen, inv_bad, stray_err, lo0, hi0, busy0, p_lo, p_hi;
    logic [11:0] mask;

    valid = skip ? (ch >= 1 && ch <= 12) : (cnt >= 1 && cnt <= 3);
    if (!valid) begin
      d = 0; err_exp = 1'b1; hi_exp = -1;
    end else begin
      prev = 0; t_tmo = -1;
      foreach (q_rise[i]) begin
        if (t_tmo < 0) begin
          if (q_rise[i] - prev > LT) t_tmo = prev + LT;
          else prev = q_rise[i];
        end
      end
      if (t_tmo < 0) t_tmo = prev + LT;
      t_line = INF;
      if (!skip && q_rise.size() >= cnt)  t_line = q_rise[cnt-1];
      if (skip  && q_rise.size() >= MAXL) t_line = q_rise[MAXL-1];
      t_stop = (skip && stop_e > 0) ? stop_e : INF;
      d = t_tmo;
      if (t_line < d) d = t_line;
      if (t_stop < d) d = t_stop;
      err_exp = (d != t_stop) && (d == t_tmo || (skip && d == t_line));
      hi_exp  = !skip ? -1 : ((slow_e > 0 && slow_e < d) ? slow_e : d);
    end
    done_exp  = d + SC - 1;
    lines_exp = 0;
    foreach (q_rise[i]) if (q_rise[i] >= 1 && q_rise[i] <= done_exp) lines_exp++;
    if (lines_exp > 255) lines_exp = 255;

    wait_ready(tag);
    mask          = (ch >= 1 && ch <= 12) ? (12'b1 << (ch - 1)) : 12'b0;
    i_cmd_valid   = 1'b1;
    i_cmd_skip    = skip;
    i_cmd_count   = 2'(cnt);
    i_cmd_channel = 4'(ch);
    tick();
    i_cmd_valid = 1'b0;
    lo0   = o_lo_start;
    hi0   = o_hi_start;
    busy0 = o_busy && !o_cmd_ready;
    p_lo  = lo0;
    p_hi  = hi0;
    lo_fall = -1; hi_fall = -1; done_k = -1; lines_seen = -1;
    err_seen = 1'b0; inv_bad = 1'b0; stray_err = 1'b0;
    limit = done_exp + 20;
    ri    = 0;
    for (int k = 1; k <= limit && done_k < 0; k++) begin
      i_mag = (ri < q_rise.size() && q_rise[ri] == k);
      if (i_mag) ri++;
      i_slow = ((noise ? 12'($urandom) : 12'b0) & ~mask) | ((slow_e > 0 && k >= slow_e) ? mask : 12'b0);
      i_stop = ((noise ? 12'($urandom) : 12'b0) & ~mask) | ((stop_e > 0 && k >= stop_e) ? mask : 12'b0);
      tick();
      if (p_lo && !o_lo_start && lo_fall < 0) lo_fall = k;
      if (p_hi && !o_hi_start && hi_fall < 0) hi_fall = k;
      p_lo = o_lo_start;
      p_hi = o_hi_start;
      if (o_lo_stop === o_lo_start || o_hi_stop === o_hi_start) inv_bad = 1'b1;
      if (o_error && !o_done) stray_err = 1'b1;
      if (o_done) begin
        done_k     = k;
        err_seen   = o_error;
        lines_seen = int'(o_lines);
      end
    end
    i_mag  = 1'b0;
    i_slow = '0;
    i_stop = '0;

    check({tag, "_lo_on"},   lo0, valid);
    check({tag, "_hi_on"},   hi0, valid && skip);
    check({tag, "_busy"},    busy0, 1);
    check({tag, "_lo_fall"}, lo_fall, valid ? d : -1);
    check({tag, "_hi_fall"}, hi_fall, valid ? hi_exp : -1);
    check({tag, "_done_at"}, done_k, done_exp);
    check({tag, "_error"},   err_seen, err_exp);
    check({tag, "_lines"},   lines_seen, lines_exp);
    check({tag, "_stopinv"}, inv_bad, 0);
    check({tag, "_stray"},   stray_err, 0);
  endtask

  task automatic clear_sched();
    q_rise.delete();
    slow_e = 0;
    stop_e = 0;
    noise  = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cnt, ch, n, e, sk;
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_skip = 1'b0; i_cmd_count = '0;
    i_cmd_channel = '0; i_mag = 1'b0; i_slow = '0; i_stop = '0;
    tick(); tick();
    check("rst_lo_start", o_lo_start, 0);
    check("rst_lo_stop",  o_lo_stop, 1);
    check("rst_hi_start", o_hi_start, 0);
    check("rst_hi_stop",  o_hi_stop, 1);
    check("rst_ready",    o_cmd_ready, 1);
    check("rst_busy",     o_busy, 0);
    check("rst_done",     o_done, 0);
    check("rst_error",    o_error, 0);
    check("rst_lines",    o_lines, 0);
    rst = 1'b0;
    tick();

    clear_sched(); q_rise = '{200, 400};
    run("space2", 1'b0, 2, 0);

    clear_sched(); for (int i = 1; i <= 7; i++) q_rise.push_back(20 * i);
    slow_e = 120; stop_e = 140; noise = 1'b1;
    run("skip3", 1'b1, 0, 3);

    clear_sched();
    run("space_tmo", 1'b0, 1, 0);

    clear_sched();
    run("count0", 1'b0, 0, 0);
    clear_sched();
    run("chan13", 1'b1, 0, 13);

    clear_sched(); q_rise = '{10, 20, 30}; slow_e = 25; stop_e = 25;
    run("slowstop_same", 1'b1, 0, 7);

    clear_sched(); q_rise = '{50, 90};
    run("space_coast", 1'b0, 1, 0);

    clear_sched(); for (int i = 1; i <= MAXL; i++) q_rise.push_back(4 * i);
    noise = 1'b1;
    run("skip_limit", 1'b1, 0, 12);

    for (int t = 0; t < 12; t++) begin
      clear_sched();
      kind = $urandom_range(0, 9);
      e = 0;
      if (kind < 4 || t == 5) begin
        cnt = $urandom_range(1, 3);
        n   = cnt + $urandom_range(0, 1);
        for (int i = 0; i < n; i++) begin
          e += (t == 5 && i == 0) ? LT + $urandom_range(1, 20) : $urandom_range(5, 300);
          q_rise.push_back(e);
        end
        run("rnd_space", 1'b0, cnt, 0);
      end else if (kind < 8) begin
        ch = $urandom_range(1, 12);
        n  = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) begin
          e += $urandom_range(3, 40);
          q_rise.push_back(e);
        end
        sk     = $urandom_range(0, n - 1);
        slow_e = q_rise[sk] + $urandom_range(0, 2);
        if ($urandom_range(0, 3) != 0) stop_e = q_rise[n-1] + $urandom_range(0, 2);
        noise = 1'b1;
        run("rnd_skip", 1'b1, 0, ch);
      end else if (kind == 8) begin
        run("rnd_cnt0", 1'b0, 0, $urandom_range(0, 15));
      end else begin
        ch = $urandom_range(0, 3);
        run("rnd_badch", 1'b1, $urandom_range(0, 3), (ch == 0) ? 0 : 12 + ch);
      end
    end

    clear_sched();
    wait_ready("rst_mid");
    i_cmd_valid = 1'b1; i_cmd_skip = 1'b1; i_cmd_channel = 4'd5; i_cmd_count = 2'd0;
    tick();
    i_cmd_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      i_mag = (k == 10 || k == 20);
      tick();
    end
    i_mag = 1'b0;
    check("mid_lo_moving", o_lo_start, 1);
    check("mid_hi_moving", o_hi_start, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_lo_start", o_lo_start, 0);
    check("mid_rst_lo_stop",  o_lo_stop, 1);
    check("mid_rst_hi_start", o_hi_start, 0);
    check("mid_rst_hi_stop",  o_hi_stop, 1);
    check("mid_rst_ready",    o_cmd_ready, 1);
    check("mid_rst_lines",    o_lines, 0);

    clear_sched(); q_rise = '{50};
    run("post_rst_space1", 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
